// File: rtl/da_wave_ctrl.sv
// da_wave_ctrl: phase-accumulator address sequencer for the DA waveform ROM.
// Turns registered ROM reads into scaled, offset-binary DAC samples with a
// valid flag. Runs continuously or for a burst of whole waveform periods.
module da_wave_ctrl #(
   parameter int unsigned PHASE_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ROM_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [PHASE_WIDTH-1:0] cfg_fword,
   input  logic [ADDR_WIDTH-1:0]  cfg_poffset,
   input  logic [2:0]             cfg_amp_shift,
   input  logic [15:0]            cfg_cycles,
   input  logic                   cfg_load,
   input  logic                   start,
   input  logic                   stop,
   output logic [ADDR_WIDTH-1:0]  rom_addr,
   input  logic [DATA_WIDTH-1:0]  rom_data,
   output logic [DATA_WIDTH-1:0]  da_data,
   output logic                   da_valid,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned SHIFT_W = 3;
   localparam int unsigned DRAIN_W = 2;
   localparam int unsigned MID     = 2 ** (DATA_WIDTH - 1);
   localparam logic signed [DATA_WIDTH:0] MID_S      = (DATA_WIDTH + 1)'(MID);
   localparam logic [DRAIN_W-1:0]         DRAIN_LAST = DRAIN_W'(ROM_LATENCY - 1);
   localparam logic [CNT_W-1:0]           CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                   r_state, w_state_nxt;
   logic [PHASE_WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic [DRAIN_W-1:0]       r_drain_cnt;
   logic                     r_addr_vld;
   logic [ROM_LATENCY-1:0]   r_tag;

   // active shadow configuration and the value held pending during RUN
   logic [PHASE_WIDTH-1:0]   r_fword,   r_p_fword;
   logic [ADDR_WIDTH-1:0]    r_poffset, r_p_poffset;
   logic [SHIFT_W-1:0]       r_amp_shift, r_p_amp_shift;
   logic [CNT_W-1:0]         r_cycles,  r_p_cycles;
   logic                     r_pend;

   logic                     w_start, w_issue, w_drain_done;
   logic [PHASE_WIDTH:0]     w_sum;
   logic [CNT_W-1:0]         w_cnt_p1;
   logic                     w_wrap_ev, w_apply;
   logic [PHASE_WIDTH-1:0]   w_new_fword;
   logic [ADDR_WIDTH-1:0]    w_new_poffset, w_off;
   logic [SHIFT_W-1:0]       w_new_amp_shift;
   logic [CNT_W-1:0]         w_new_cycles;
   logic signed [DATA_WIDTH:0] w_s, w_sh;

   assign w_sum     = {1'b0, r_acc} + {1'b0, r_fword};
   assign w_cnt_p1  = r_cnt + CNT_W'(1);
   assign w_wrap_ev = (r_state == S_RUN) && !stop && w_sum[PHASE_WIDTH];
   assign w_apply   = w_wrap_ev && (cfg_load || r_pend);

   // a load arriving in the wrap cycle itself beats the older pending one
   assign w_new_fword     = cfg_load ? cfg_fword     : r_p_fword;
   assign w_new_poffset   = cfg_load ? cfg_poffset   : r_p_poffset;
   assign w_new_amp_shift = cfg_load ? cfg_amp_shift : r_p_amp_shift;
   assign w_new_cycles    = cfg_load ? cfg_cycles    : r_p_cycles;
   assign w_off           = w_apply ? w_new_poffset : r_poffset;

   assign w_s  = $signed({1'b0, rom_data}) - MID_S;
   assign w_sh = w_s >>> r_amp_shift;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state and control strobes
   always_comb begin
      w_state_nxt  = r_state;
      w_start      = 1'b0;
      w_issue      = 1'b0;
      w_drain_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_state_nxt = S_RUN;
               w_start     = 1'b1;
            end
         end
         S_RUN: begin
            if (stop) begin
               w_state_nxt = S_DRAIN;
            end else if (w_sum[PHASE_WIDTH] && (r_cycles != '0) && (w_cnt_p1 == r_cycles)) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_issue = 1'b1;
            end
         end
         S_DRAIN: begin
            if (r_drain_cnt == DRAIN_LAST) begin
               w_state_nxt  = S_IDLE;
               w_drain_done = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // accumulator, address issue, period counter, drain timer, status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_drain_cnt <= '0;
         r_addr_vld  <= 1'b0;
         rom_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy        <= (w_state_nxt != S_IDLE);
         done        <= w_drain_done;
         r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
         if (w_start) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            rom_addr   <= r_poffset;
            r_addr_vld <= 1'b1;
         end else if (w_issue) begin
            r_acc      <= w_sum[PHASE_WIDTH-1:0];
            rom_addr   <= w_sum[PHASE_WIDTH-1 -: ADDR_WIDTH] + w_off;
            r_addr_vld <= 1'b1;
            if (w_sum[PHASE_WIDTH] && (r_cnt != CNT_MAX)) r_cnt <= w_cnt_p1;
         end else begin
            r_addr_vld <= 1'b0;
         end
      end
   end

   // shadow config: direct in IDLE, deferred to the next phase wrap otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fword       <= '0;
         r_poffset     <= '0;
         r_amp_shift   <= '0;
         r_cycles      <= '0;
         r_p_fword     <= '0;
         r_p_poffset   <= '0;
         r_p_amp_shift <= '0;
         r_p_cycles    <= '0;
         r_pend        <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (cfg_load || r_pend) begin
            r_fword     <= w_new_fword;
            r_poffset   <= w_new_poffset;
            r_amp_shift <= w_new_amp_shift;
            r_cycles    <= w_new_cycles;
         end
         r_pend <= 1'b0;
      end else if (w_apply) begin
         r_fword     <= w_new_fword;
         r_poffset   <= w_new_poffset;
         r_amp_shift <= w_new_amp_shift;
         r_cycles    <= w_new_cycles;
         r_pend      <= 1'b0;
      end else if (cfg_load) begin
         r_p_fword     <= cfg_fword;
         r_p_poffset   <= cfg_poffset;
         r_p_amp_shift <= cfg_amp_shift;
         r_p_cycles    <= cfg_cycles;
         r_pend        <= 1'b1;
      end
   end

   // valid tags follow issued addresses through the ROM read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag <= '0;
      end else begin
         r_tag[0] <= r_addr_vld;
         for (int unsigned i = 1; i < ROM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   // amplitude scaling about midscale, registered to the DAC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         da_data  <= DATA_WIDTH'(MID);
         da_valid <= 1'b0;
      end else if (r_tag[ROM_LATENCY-1]) begin
         da_data  <= DATA_WIDTH'(w_sh + MID_S);
         da_valid <= 1'b1;
      end else begin
         da_data  <= DATA_WIDTH'(MID);
         da_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_da_wave_ctrl.sv
// Directed bench for da_wave_ctrl: one DUT with ROM latency 1, one with 2.
module tb_da_wave_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cfg_fword;
   logic [9:0]  cfg_poffset;
   logic [2:0]  cfg_amp_shift;
   logic [15:0] cfg_cycles;
   logic        cfg_load, start, stop;
   logic [9:0]  rom_addr1, rom_addr2;
   logic [7:0]  rom_data1, rom_data2, da1, da2;
   logic        v1, v2, busy1, busy2, done1, done2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // ROM contents model: value as a function of address
   function automatic logic [7:0] rom_f(input logic [9:0] a);
      return a[8:1] ^ {a[0], a[9], 6'b0};
   endfunction

   // registered-read ROM models, latency 1 and 2
   logic [7:0] r1a, r2a, r2b;
   always @(posedge clk) begin
      r1a <= rom_f(rom_addr1);
      r2a <= rom_f(rom_addr2);
      r2b <= r2a;
   end
   assign rom_data1 = r1a;
   assign rom_data2 = r2b;

   da_wave_ctrl #(.ROM_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .cfg_fword(cfg_fword), .cfg_poffset(cfg_poffset),
      .cfg_amp_shift(cfg_amp_shift), .cfg_cycles(cfg_cycles), .cfg_load(cfg_load),
      .start(start), .stop(stop), .rom_addr(rom_addr1), .rom_data(rom_data1),
      .da_data(da1), .da_valid(v1), .busy(busy1), .done(done1));

   da_wave_ctrl #(.ROM_LATENCY(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_fword(cfg_fword), .cfg_poffset(cfg_poffset),
      .cfg_amp_shift(cfg_amp_shift), .cfg_cycles(cfg_cycles), .cfg_load(cfg_load),
      .start(start), .stop(stop), .rom_addr(rom_addr2), .rom_data(rom_data2),
      .da_data(da2), .da_valid(v2), .busy(busy2), .done(done2));

   // sample recorder
   logic [7:0] q1[$], q2[$];
   int done1_n = 0, done2_n = 0;
   logic dwv1 = 1'b0, dwv2 = 1'b0;
   always @(negedge clk) begin
      if (v1) q1.push_back(da1);
      if (v2) q2.push_back(da2);
      if (done1) begin done1_n++; dwv1 = v1; end
      if (done2) begin done2_n++; dwv2 = v2; end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input logic [31:0] fw, input logic [9:0] po,
                          input logic [2:0] sh, input logic [15:0] cy);
      cfg_fword = fw; cfg_poffset = po; cfg_amp_shift = sh; cfg_cycles = cy;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy1 || busy2) && n < 5000) begin
         tick();
         n++;
      end
      check(tag, 32'(busy1 | busy2), 32'd0);
      tick();
      tick();
   endtask

   initial begin
      int b1, b2, d1, d2, e;
      rst_n = 1'b0;
      cfg_fword = '0; cfg_poffset = '0; cfg_amp_shift = '0; cfg_cycles = '0;
      cfg_load = 1'b0; start = 1'b0; stop = 1'b0;
      #12;
      check("rst_addr",  32'(rom_addr1), 32'd0);
      check("rst_data",  32'(da1),       32'h80);
      check("rst_valid", 32'(v1),        32'd0);
      check("rst_busy",  32'(busy1),     32'd0);
      check("rst_done",  32'(done1),     32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // full-rate sweep, one period
      set_cfg(32'h0040_0000, 10'd0, 3'd0, 16'd1);
      b1 = q1.size(); b2 = q2.size(); d1 = done1_n; d2 = done2_n;
      pulse_start();
      check("sweep_busy_t1",  32'(busy1),     32'd1);
      check("sweep_addr_t1",  32'(rom_addr1), 32'd0);
      check("sweep_valid_t1", 32'(v1),        32'd0);
      tick();
      check("sweep_addr_t2",  32'(rom_addr1), 32'd1);
      check("sweep_valid_t2", 32'(v1),        32'd0);
      tick();
      check("sweep_valid_t3", 32'(v1),        32'd1);
      check("sweep_data_t3",  32'(da1),       32'(rom_f(10'd0)));
      wait_idle("sweep_timeout");
      check("sweep_count1", 32'(q1.size() - b1), 32'd1024);
      check("sweep_count2", 32'(q2.size() - b2), 32'd1024);
      check("sweep_done1",  32'(done1_n - d1),   32'd1);
      check("sweep_done2",  32'(done2_n - d2),   32'd1);
      check("sweep_done_with_valid1", 32'(dwv1), 32'd1);
      check("sweep_done_with_valid2", 32'(dwv2), 32'd1);
      if (q1.size() - b1 == 1024 && q2.size() - b2 == 1024)
         for (int i = 0; i < 1024; i++) begin
            check("sweep_sample1", 32'(q1[b1+i]), 32'(rom_f(10'(i))));
            check("sweep_sample2", 32'(q2[b2+i]), 32'(rom_f(10'(i))));
         end

      // offset + amplitude, two periods at step 2
      set_cfg(32'h0080_0000, 10'd256, 3'd1, 16'd2);
      b1 = q1.size(); d1 = done1_n;
      pulse_start();
      wait_idle("offs_timeout");
      check("offs_count", 32'(q1.size() - b1), 32'd1024);
      check("offs_done",  32'(done1_n - d1),   32'd1);
      if (q1.size() - b1 == 1024) begin
         for (int i = 0; i < 1024; i++) begin
            int v;
            v = int'(rom_f(10'((256 + 2 * i) % 1024))) - 128;
            v = v >>> 1;
            check("offs_sample", 32'(q1[b1+i]), 32'(v + 128));
         end
         check("offs_ff_to_bf", 32'(q1[b1+127]), 32'hBF);
         check("offs_00_to_40", 32'(q1[b1+384]), 32'h40);
      end

      // stop at RUN cycle 10, continuous mode
      set_cfg(32'h0040_0000, 10'd0, 3'd0, 16'd0);
      b1 = q1.size(); b2 = q2.size(); d1 = done1_n; d2 = done2_n;
      pulse_start();
      repeat (9) tick();
      pulse_stop();
      wait_idle("stop_timeout");
      check("stop_count1", 32'(q1.size() - b1), 32'd10);
      check("stop_count2", 32'(q2.size() - b2), 32'd10);
      check("stop_done1",  32'(done1_n - d1),   32'd1);
      check("stop_done2",  32'(done2_n - d2),   32'd1);
      check("stop_done_with_valid1", 32'(dwv1), 32'd1);
      check("stop_idle_data",  32'(da1), 32'h80);
      check("stop_idle_valid", 32'(v1),  32'd0);
      if (q1.size() - b1 == 10 && q2.size() - b2 == 10)
         for (int i = 0; i < 10; i++) begin
            check("stop_sample1", 32'(q1[b1+i]), 32'(rom_f(10'(i))));
            check("stop_sample2", 32'(q2[b2+i]), 32'(rom_f(10'(i))));
         end

      // start and stop together in IDLE
      b1 = q1.size(); b2 = q2.size(); d1 = done1_n;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("ss_busy1", 32'(busy1), 32'd0);
      check("ss_busy2", 32'(busy2), 32'd0);
      repeat (6) tick();
      check("ss_count1", 32'(q1.size() - b1), 32'd0);
      check("ss_count2", 32'(q2.size() - b2), 32'd0);
      check("ss_done",   32'(done1_n - d1),   32'd0);

      // retune mid-period: step changes only at the wrap
      set_cfg(32'h0040_0000, 10'd0, 3'd0, 16'd0);
      pulse_start();
      for (int k = 1; k <= 1040; k++) begin
         e = (k <= 1024) ? (k - 1) : 4 * (k - 1025);
         check("retune_addr", 32'(rom_addr1), 32'(e));
         if (k == 100) begin
            cfg_fword = 32'h0100_0000;
            cfg_load  = 1'b1;
         end
         tick();
         cfg_load = 1'b0;
      end
      pulse_stop();
      wait_idle("retune_timeout");

      // zero frequency word holds one address until stopped
      set_cfg(32'h0000_0000, 10'd5, 3'd0, 16'd0);
      d1 = done1_n;
      pulse_start();
      repeat (3) tick();
      for (int k = 0; k < 30; k++) begin
         check("zero_addr",  32'(rom_addr1), 32'd5);
         check("zero_valid", 32'(v1),        32'd1);
         check("zero_data",  32'(da1),       32'(rom_f(10'd5)));
         check("zero_done",  32'(done1),     32'd0);
         tick();
      end
      pulse_stop();
      wait_idle("zero_timeout");
      check("zero_done_after_stop", 32'(done1_n - d1), 32'd1);

      // asynchronous reset in the middle of RUN
      set_cfg(32'h0040_0000, 10'd0, 3'd0, 16'd0);
      pulse_start();
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      check("mrst_addr",  32'(rom_addr1), 32'd0);
      check("mrst_data",  32'(da1),       32'h80);
      check("mrst_valid", 32'(v1),        32'd0);
      check("mrst_busy1", 32'(busy1),     32'd0);
      check("mrst_busy2", 32'(busy2),     32'd0);
      check("mrst_done",  32'(done1),     32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      set_cfg(32'h0040_0000, 10'd0, 3'd0, 16'd0);
      b1 = q1.size(); d1 = done1_n;
      pulse_start();
      repeat (9) tick();
      pulse_stop();
      wait_idle("mrst_timeout");
      check("mrst_count", 32'(q1.size() - b1), 32'd10);
      check("mrst_done_n", 32'(done1_n - d1),  32'd1);
      if (q1.size() - b1 == 10)
         for (int i = 0; i < 10; i++)
            check("mrst_sample", 32'(q1[b1+i]), 32'(rom_f(10'(i))));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/da_wave_ctrl.md
# da_wave_ctrl

Sequencer for the DA waveform ROM (10-bit address, 8-bit sine table, registered read) on the ADDA/HDMI test card. A phase accumulator generates ROM addresses at a programmable frequency and phase offset. It compensates for the ROM read latency, applies amplitude scaling about midscale, and presents offset-binary samples with a valid flag to the DAC interface. It supports continuous output or bursts of N whole waveform periods.

## Interface
- PHASE_WIDTH, 32, phase accumulator width; ROM address = top ADDR_WIDTH bits
- ADDR_WIDTH, 10, ROM address width
- DATA_WIDTH, 8, ROM/DAC sample width, offset binary
- ROM_LATENCY, 1, cycles from rom_addr to rom_data valid; legal 1 or 2
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_fword  in  PHASE_WIDTH  frequency tuning word, added per RUN cycle
- cfg_poffset  in  ADDR_WIDTH  phase offset added to address, mod 2^ADDR_WIDTH
- cfg_amp_shift  in  3  amplitude attenuation, arithmetic right shift of (sample − midscale)
- cfg_cycles  in  16  periods per burst; 0 = continuous
- cfg_load  in  1  one-cycle pulse; captures all cfg_* into shadow registers
- start  in  1  one-cycle pulse; begin generation
- stop  in  1  one-cycle pulse; abort generation
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_data  in  DATA_WIDTH  ROM read data
- da_data  out  DATA_WIDTH  DAC sample
- da_valid  out  1  da_data is a live waveform sample
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when a burst completes or a stop drain finishes

## Operation
- States: IDLE, RUN, DRAIN.
- Reset values:
  - state = IDLE, phase accumulator = 0, all shadow registers = 0.
  - Outputs: rom_addr = 0, da_data = 2^(DATA_WIDTH−1) (0x80), da_valid = 0, busy = 0, done = 0.
- Shadow configuration:
  - cfg_load in IDLE takes effect on the next cycle.
  - cfg_load in RUN is held pending and applied on the cycle of the next phase wrap (accumulator carry-out). This keeps frequency and amplitude changes glitch-free.
  - A second cfg_load while one is pending overwrites the pending values.
  - If cfg_load and a wrap occur in the same cycle, the new values apply at that wrap.
- IDLE → RUN on start:
  - The accumulator is cleared to 0 and the period counter is cleared.
  - If start and stop arrive in the same cycle, stop wins and the block stays in IDLE.
- RUN:
  - rom_addr = acc[PHASE_WIDTH−1 : PHASE_WIDTH−ADDR_WIDTH] + poffset, registered.
  - acc += fword each cycle, modulo 2^PHASE_WIDTH.
  - Each carry-out increments the period counter.
  - If cycles ≠ 0 and the counter reaches cycles: go to DRAIN. The address issued in the wrap cycle is not counted as a sample.
  - fword = 0 holds a constant address and never wraps; the block then runs until stop.
  - start in RUN or DRAIN is ignored.
- RUN → DRAIN on stop or burst end. No new addresses are issued, and rom_addr holds its last value.
- DRAIN:
  - Lasts exactly ROM_LATENCY cycles, so every issued address yields exactly one da_valid sample.
  - Then → IDLE with a done pulse.
  - stop in DRAIN has no effect.
- Sample path:
  - A valid-tag shift register of depth ROM_LATENCY tracks issued addresses.
  - When a tag emerges: s = rom_data − 2^(DATA_WIDTH−1), signed, DATA_WIDTH+1 bits.
  - da_data = (s >>> amp_shift) + 2^(DATA_WIDTH−1), registered; da_valid = 1.
  - The shift cannot overflow. amp_shift is sampled in the same cycle as the tag.
  - When no tag emerges: da_data = midscale, da_valid = 0.

## Timing
- start at edge T:
  - busy = 1 from T+1.
  - The first rom_addr (acc=0, i.e. poffset) is valid at T+1.
  - The first da_valid occurs at T+1+ROM_LATENCY+1, counting the output register.
- Throughput is one sample per clock in RUN. da_valid stays continuously high from the first sample until ROM_LATENCY+1 cycles after the last address.
- done asserts in the same cycle as the final da_valid, and busy drops in that cycle. The block accepts start again in the next cycle.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronously); pending cfg is discarded.
- The burst counter is 16-bit. cycles = 65535 is legal. In continuous mode the counter saturates rather than wrapping.

## Test plan
- Reset: assert rst_n=0 mid-RUN → da_valid=0, da_data=0x80, busy=0, rom_addr=0 within the same cycle; release, start → output is clean.
- Full-rate sweep: fword=0x0040_0000, poffset=0, shift=0, cycles=1 → addresses 0,1,…,1023 once each. Exactly 1024 da_valid samples equal to ROM[0..1023], then a done pulse and busy=0.
- Offset/amplitude: fword=0x0080_0000, poffset=256, shift=1, cycles=2 → addresses 256,258,…, wrapping mod 1024. 1024 samples total, each equal to ((ROM[a]−128)>>>1)+128; ROM 0xFF→0xBF, ROM 0x00→0x40.
- Stop/drain: continuous mode, stop at RUN cycle 10 → exactly 10 da_valid samples, then done, then idle at 0x80. With ROM_LATENCY=2, still exactly 10 samples; start+stop in the same IDLE cycle → no activity.
- Glitch-free retune: in RUN with fword=0x0040_0000, cfg_load with fword=0x0100_0000 mid-period → address step stays 1 until the wrap to address 0, then becomes 4. No partial period at the new step before the wrap.
- Zero fword: fword=0, poffset=5, continuous → rom_addr stays at 5 and da_data=ROM[5] every cycle, with no done, until stop.
